// File: rtl/fht_bank_loader.sv
// Writer side of the four-bank FHT data memory: streams N = 4*2^ADDR_BIT samples
// into the banks at bit-reversed positions so butterfly stage 0 reads them in order.
//
// state | meaning
// IDLE  | waiting for iSTART, no writes
// LOAD  | accepting samples, one bank write per accepted sample
// FLUSH | final write on the bus (oDONE high), back to IDLE next cycle
module fht_bank_loader #(
    parameter int D_BIT    = 17,
    parameter int ADDR_BIT = 8
) (
    input  logic                iCLK,
    input  logic                iRESET,
    input  logic                iSTART,
    input  logic [D_BIT-1:0]    iDATA,
    input  logic                iVALID,
    output logic                oREADY,
    output logic [3:0]          oWE,
    output logic [ADDR_BIT-1:0] oADDR,
    output logic [D_BIT-1:0]    oDATA,
    output logic                oBUSY,
    output logic                oDONE
);

    localparam int CNT_BIT = ADDR_BIT + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_BIT-1:0] cnt;
    logic [CNT_BIT-1:0] rev;
    logic               accept;

    always_comb begin
        rev = '0;
        for (int k = 0; k < CNT_BIT; k++) begin
            rev[k] = cnt[CNT_BIT-1-k];
        end
    end

    assign oREADY = (state == LOAD);
    assign oBUSY  = (state != IDLE);
    assign accept = iVALID && (state == LOAD);

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state <= IDLE;
            cnt   <= '0;
            oWE   <= '0;
            oADDR <= '0;
            oDATA <= '0;
            oDONE <= 1'b0;
        end else begin
            oWE   <= '0;
            oDONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (iSTART) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        // low two bits of the reversed index pick the bank
                        oWE   <= 4'b0001 << rev[1:0];
                        oADDR <= rev[CNT_BIT-1:2];
                        oDATA <= iDATA;
                        if (cnt == '1) begin
                            state <= FLUSH;
                            cnt   <= '0;
                            oDONE <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fht_bank_loader.sv
// Self-checking bench for fht_bank_loader: behavioural model checked every cycle,
// bank-memory scoreboard per frame, and literal spot checks on the mapping.
module tb_fht_bank_loader;

    localparam int D_BIT    = 17;
    localparam int ADDR_BIT = 8;
    localparam int N        = 4 * (2 ** ADDR_BIT);
    localparam int LOG_N    = ADDR_BIT + 2;

    logic                iCLK = 1'b0;
    logic                iRESET;
    logic                iSTART;
    logic [D_BIT-1:0]    iDATA;
    logic                iVALID;
    logic                oREADY;
    logic [3:0]          oWE;
    logic [ADDR_BIT-1:0] oADDR;
    logic [D_BIT-1:0]    oDATA;
    logic                oBUSY;
    logic                oDONE;

    logic                s_start;
    logic [D_BIT-1:0]    s_data;
    logic                s_valid;
    logic                s_ready;
    logic [3:0]          s_we;
    logic [0:0]          s_addr;
    logic [D_BIT-1:0]    s_data_o;
    logic                s_busy;
    logic                s_done;

    fht_bank_loader #(.D_BIT(D_BIT), .ADDR_BIT(ADDR_BIT)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iDATA(iDATA),
        .iVALID(iVALID), .oREADY(oREADY), .oWE(oWE), .oADDR(oADDR),
        .oDATA(oDATA), .oBUSY(oBUSY), .oDONE(oDONE)
    );

    fht_bank_loader #(.D_BIT(D_BIT), .ADDR_BIT(1)) dut_small (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(s_start), .iDATA(s_data),
        .iVALID(s_valid), .oREADY(s_ready), .oWE(s_we), .oADDR(s_addr),
        .oDATA(s_data_o), .oBUSY(s_busy), .oDONE(s_done)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int bitrev(input int v, input int bits);
        int r = 0;
        for (int k = 0; k < bits; k++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // Behavioural model: loading flag, index of next sample, and a pending flush.
    bit                  m_loading = 0;
    bit                  m_flush   = 0;
    int                  m_idx     = 0;
    logic [3:0]          e_we      = '0;
    logic [ADDR_BIT-1:0] e_addr    = '0;
    logic [D_BIT-1:0]    e_data    = '0;
    logic                e_done    = 1'b0;

    always @(posedge iCLK) begin
        int r;
        if (!iRESET) begin
            m_loading = 0; m_flush = 0; m_idx = 0;
            e_we = '0; e_addr = '0; e_data = '0; e_done = 1'b0;
        end else begin
            e_we   = '0;
            e_done = 1'b0;
            if (m_flush) begin
                m_flush = 0;
            end else if (m_loading) begin
                if (iVALID) begin
                    r      = bitrev(m_idx, LOG_N);
                    e_we   = 4'(1 << (r % 4));
                    e_addr = ADDR_BIT'(r / 4);
                    e_data = iDATA;
                    if (m_idx == N - 1) begin
                        e_done = 1'b1; m_loading = 0; m_flush = 1; m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end else if (iSTART) begin
                m_loading = 1;
                m_idx     = 0;
            end
        end
    end

    bit               chk_en    = 0;
    bit               spot_mode = 0;
    int               writes    = 0;
    int               dones     = 0;
    int               frame_wr  = 0;
    logic [D_BIT-1:0] mem     [4][2**ADDR_BIT];
    bit               written [4][2**ADDR_BIT];
    logic [D_BIT-1:0] samples [N];

    always @(negedge iCLK) begin
        if (chk_en) begin
            chk("we", 32'(oWE), 32'(e_we));
            chk("addr", 32'(oADDR), 32'(e_addr));
            chk("data", 32'(oDATA), 32'(e_data));
            chk("done", 32'(oDONE), 32'(e_done));
            chk("busy", 32'(oBUSY), 32'(m_loading || m_flush));
            chk("ready", 32'(oREADY), 32'(m_loading));
            if (oWE != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (oWE[k]) begin
                        mem[k][oADDR]     = oDATA;
                        written[k][oADDR] = 1;
                    end
                end
                if (spot_mode) begin
                    chk("spot_data", 32'(oDATA), 32'(frame_wr));
                    case (frame_wr)
                        0:    begin chk("spot0_we", 32'(oWE), 32'h1); chk("spot0_addr", 32'(oADDR), 32'd0); end
                        1:    begin chk("spot1_we", 32'(oWE), 32'h1); chk("spot1_addr", 32'(oADDR), 32'd128); end
                        2:    begin chk("spot2_we", 32'(oWE), 32'h1); chk("spot2_addr", 32'(oADDR), 32'd64); end
                        3:    begin chk("spot3_we", 32'(oWE), 32'h1); chk("spot3_addr", 32'(oADDR), 32'd192); end
                        512:  begin chk("spot512_we", 32'(oWE), 32'h2); chk("spot512_addr", 32'(oADDR), 32'd0); end
                        1023: begin
                            chk("spot1023_we", 32'(oWE), 32'h8);
                            chk("spot1023_addr", 32'(oADDR), 32'd255);
                            chk("spot1023_done", 32'(oDONE), 32'd1);
                        end
                        default: ;
                    endcase
                end
                writes++;
                frame_wr++;
            end
            if (oDONE) dones++;
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic clear_frame();
        writes = 0; dones = 0; frame_wr = 0;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 2**ADDR_BIT; a++) written[b][a] = 0;
    endtask

    task automatic pulse_start();
        iSTART = 1; tick(); iSTART = 0;
    endtask

    task automatic send(input int n, input int mode, input int gap_pct, input int restart_at);
        logic [D_BIT-1:0] d;
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                iVALID = 0; iDATA = D_BIT'($urandom); tick();
            end
            case (mode)
                0:       d = D_BIT'(i);
                1:       d = D_BIT'($urandom);
                default: d = (i == 1000) ? 17'h10000 : D_BIT'(-i);  // most negative value rides along
            endcase
            samples[i] = d;
            iDATA  = d;
            iVALID = 1;
            iSTART = (i == restart_at);
            tick();
            iSTART = 0;
        end
        iVALID = 0;
    endtask

    task automatic check_frame(input string nm);
        int r;
        chk({nm, "_writes"}, 32'(writes), 32'(N));
        chk({nm, "_dones"}, 32'(dones), 32'd1);
        for (int i = 0; i < N; i++) begin
            r = bitrev(i, LOG_N);
            chk({nm, "_sb"}, {14'd0, written[r % 4][r / 4], mem[r % 4][r / 4]}, {14'd0, 1'b1, samples[i]});
        end
    endtask

    int bank_tbl [8] = '{0, 0, 2, 2, 1, 1, 3, 3};

    initial begin
        iRESET = 0; iSTART = 0; iVALID = 0; iDATA = '0;
        s_start = 0; s_valid = 0; s_data = '0;
        tick();
        chk_en = 1;
        tick();
        iRESET = 1;

        chk("rst_we", 32'(oWE), 32'd0);
        chk("rst_addr", 32'(oADDR), 32'd0);
        chk("rst_data", 32'(oDATA), 32'd0);
        chk("rst_busy", 32'(oBUSY), 32'd0);
        chk("rst_ready", 32'(oREADY), 32'd0);
        chk("rst_done", 32'(oDONE), 32'd0);

        clear_frame();
        iVALID = 1; iDATA = 17'h1abc;
        repeat (5) tick();
        iVALID = 0;
        chk("idle_valid_writes", 32'(writes), 32'd0);

        pulse_start();
        send(10, 0, 0, -1);
        iRESET = 0; tick(); iRESET = 1;
        chk("midrst_we", 32'(oWE), 32'd0);
        chk("midrst_busy", 32'(oBUSY), 32'd0);
        chk("midrst_ready", 32'(oREADY), 32'd0);
        tick();
        pulse_start();
        iDATA = 17'h00055; iVALID = 1; tick(); iVALID = 0;
        chk("restart_we", 32'(oWE), 32'h1);
        chk("restart_addr", 32'(oADDR), 32'd0);
        iRESET = 0; tick(); iRESET = 1; tick();

        clear_frame();
        spot_mode = 1;
        pulse_start();
        send(N, 0, 0, 300);
        iSTART = 1; iVALID = 1; tick(); iSTART = 0;
        repeat (4) tick();
        iVALID = 0;
        spot_mode = 0;
        chk("flush_start_busy", 32'(oBUSY), 32'd0);
        check_frame("spot");

        clear_frame();
        pulse_start();
        send(N, 1, 30, -1);
        tick();
        check_frame("rand");

        clear_frame();
        pulse_start();
        send(N, 2, 10, -1);
        repeat (3) tick();
        check_frame("neg");
        chk("neg_i1", 32'(mem[0][128]), 32'h1ffff);
        chk("neg_min", 32'(mem[3][23]), 32'h10000);

        s_start = 1; tick(); s_start = 0;
        chk("small_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            s_data = D_BIT'(i); s_valid = 1; tick();
            chk("small_we", 32'(s_we), 32'(1 << bank_tbl[i]));
            chk("small_addr", 32'(s_addr), 32'(i % 2));
            chk("small_data", 32'(s_data_o), 32'(i));
            chk("small_done", 32'(s_done), 32'(i == 7));
        end
        s_valid = 0; tick();
        chk("small_idle", 32'(s_busy), 32'd0);

        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
